// File: rtl/hvac_pkg.sv
// Shared definitions for the HVAC actuator stage: state encoding, the
// request codes exchanged with the AC controller, and default timing.
package hvac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HEAT = 2'b01,
        ST_COOL = 2'b10,
        ST_REST = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        AC_IDEAL   = 2'b00,
        AC_COOLING = 2'b01,
        AC_HEATING = 2'b10
    } ac_req_e;

    localparam int DEF_MIN_ON  = 8;
    localparam int DEF_MIN_OFF = 6;
    localparam int DEF_FAN_RUN = 4;
    localparam int DEF_CNT_W   = 8;

    // Collapse the two request lines into one code. A contradictory
    // request (both high) is treated as "no valid request".
    function automatic ac_req_e decode_req(input logic heat, input logic cool);
        case ({heat, cool})
            2'b10:   return AC_HEATING;
            2'b01:   return AC_COOLING;
            default: return AC_IDEAL;
        endcase
    endfunction

endpackage

// File: rtl/hvac_actuator_ctrl_dwell_timer.sv
// Saturating dwell counter: synchronous clear, count enable, async reset.
// Also exposes the value it will hold after the next edge so registered
// outputs can be computed from it.
module dwell_timer
    import hvac_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_next_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise increment until saturated.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/hvac_actuator_ctrl.sv
// HVAC actuator controller: turns heating/cooling requests into heater,
// cooler and fan enables with minimum on-time, post-off rest period, fan
// overrun, mutual exclusion of heater/cooler, and a contradiction fault.
module hvac_actuator_ctrl
    import hvac_pkg::*;
#(
    parameter int MIN_ON  = DEF_MIN_ON,
    parameter int MIN_OFF = DEF_MIN_OFF,
    parameter int FAN_RUN = DEF_FAN_RUN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       heating_req,
    input  logic       cooling_req,
    output logic       heater_en,
    output logic       cooler_en,
    output logic       fan_en,
    output logic [1:0] state,
    output logic       fault
);

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF - 1);
    localparam logic [CNT_W-1:0] FAN_LIM  = CNT_W'(FAN_RUN);

    state_e           state_q;
    state_e           state_d;
    ac_req_e          req;
    logic             heater_q;
    logic             heater_d;
    logic             cooler_q;
    logic             cooler_d;
    logic             fan_q;
    logic             fan_d;
    logic             fault_q;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;

    assign req = decode_req(heating_req, cooling_req);

    // Next-state logic; actuators only release after their minimum on-time
    // and every release goes through REST.
    always_comb begin
        // NOTE: default assigned first so every path drives state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req == AC_HEATING) begin
                    state_d = ST_HEAT;
                end else if (req == AC_COOLING) begin
                    state_d = ST_COOL;
                end
            end
            ST_HEAT: begin
                if ((req != AC_HEATING) && (cnt_q >= ON_LAST)) begin
                    state_d = ST_REST;
                end
            end
            ST_COOL: begin
                if ((req != AC_COOLING) && (cnt_q >= ON_LAST)) begin
                    state_d = ST_REST;
                end
            end
            ST_REST: begin
                if (cnt_q == OFF_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The dwell counter restarts on every state entry.
    assign cnt_clr = (state_d != state_q);

    dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (cnt_clr),
        .en_i         (1'b1),
        .count_o      (cnt_q),
        .count_next_o (cnt_next)
    );

    // Output decode from the upcoming state so enables are registered
    // alongside the state they belong to.
    always_comb begin
        heater_d = (state_d == ST_HEAT);
        cooler_d = (state_d == ST_COOL);
        fan_d    = (state_d == ST_HEAT) || (state_d == ST_COOL) ||
                   ((state_d == ST_REST) && (cnt_next < FAN_LIM));
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            heater_q <= 1'b0;
            cooler_q <= 1'b0;
            fan_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q  <= state_d;
            heater_q <= heater_d;
            cooler_q <= cooler_d;
            fan_q    <= fan_d;
            fault_q  <= heating_req & cooling_req;
        end
    end

    assign heater_en = heater_q;
    assign cooler_en = cooler_q;
    assign fan_en    = fan_q;
    assign state     = state_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_hvac_actuator_ctrl.sv
// Self-checking bench for hvac_actuator_ctrl: a cycle model of the
// actuator rules checked every cycle, plus directed literal checkpoints.
module tb_hvac_actuator_ctrl;

    localparam int MIN_ON  = 8;
    localparam int MIN_OFF = 6;
    localparam int FAN_RUN = 4;

    logic       clk;
    logic       rst_n;
    logic       heating_req;
    logic       cooling_req;
    logic       heater_en;
    logic       cooler_en;
    logic       fan_en;
    logic [1:0] state;
    logic       fault;

    int tests;
    int fails;

    hvac_actuator_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .heating_req (heating_req),
        .cooling_req (cooling_req),
        .heater_en   (heater_en),
        .cooler_en   (cooler_en),
        .fan_en      (fan_en),
        .state       (state),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: which actuator is on and for how long, and how much rest remains.
    int m_active;     // 0 none, 1 heater, 2 cooler
    int m_on;         // cycles the active actuator has been on
    int m_rest_left;  // rest cycles still to serve
    int m_rest_age;   // rest cycles already served
    logic m_fault;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active    <= 0;
            m_on        <= 0;
            m_rest_left <= 0;
            m_rest_age  <= 0;
            m_fault     <= 1'b0;
        end else begin
            m_fault <= heating_req & cooling_req;
            if (m_rest_left > 0) begin
                m_rest_left <= m_rest_left - 1;
                m_rest_age  <= m_rest_age + 1;
            end else if (m_active == 0) begin
                if (heating_req && !cooling_req) begin
                    m_active <= 1;
                    m_on     <= 1;
                end else if (cooling_req && !heating_req) begin
                    m_active <= 2;
                    m_on     <= 1;
                end
            end else begin
                if (((m_active == 1) ? (!heating_req || cooling_req)
                                     : (!cooling_req || heating_req)) && (m_on >= MIN_ON)) begin
                    m_active    <= 0;
                    m_rest_left <= MIN_OFF;
                    m_rest_age  <= 0;
                end else begin
                    m_on <= m_on + 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [1:0] exp_state;
        logic       exp_fan;
        exp_state = (m_rest_left > 0) ? 2'b11 : 2'(m_active);
        exp_fan   = (m_active != 0) || ((m_rest_left > 0) && (m_rest_age < FAN_RUN));
        check("cyc_state",  {2'b0, state},      {2'b0, exp_state});
        check("cyc_heater", {3'b0, heater_en},  {3'b0, (m_active == 1)});
        check("cyc_cooler", {3'b0, cooler_en},  {3'b0, (m_active == 2)});
        check("cyc_fan",    {3'b0, fan_en},     {3'b0, exp_fan});
        check("cyc_fault",  {3'b0, fault},      {3'b0, m_fault});
        check("cyc_excl",   {3'b0, heater_en & cooler_en}, 4'h0);
    end

    // Advance n rising edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst_n       = 1'b0;
        heating_req = 1'b0;
        cooling_req = 1'b0;
        #1;
        check("rst_state", {2'b0, state}, 4'h0);
        check("rst_outs",  {heater_en, cooler_en, fan_en, fault}, 4'h0);
        step(2);
        #3 rst_n = 1'b1;
        step(2);

        // 1: short heat pulse still yields MIN_ON, then rest with fan overrun.
        heating_req = 1'b1;
        step(1);
        check("t1_heat_k", {heater_en, fan_en, state}, 4'b1101);
        step(1);
        heating_req = 1'b0;
        step(6);
        check("t1_heat_k7", {heater_en, fan_en, state}, 4'b1101);
        step(1);
        check("t1_rest_k8", {heater_en, fan_en, state}, 4'b0111);
        step(3);
        check("t1_fan_k11", {2'b0, fan_en, 1'b0}, 4'b0010);
        step(1);
        check("t1_fan_k12", {2'b0, fan_en, 1'b0}, 4'b0000);
        step(1);
        check("t1_rest_k13", {2'b0, state}, 4'h3);
        step(1);
        check("t1_idle_k14", {2'b0, state}, 4'h0);
        step(2);

        // 2: long cool request, cooler follows it exactly.
        cooling_req = 1'b1;
        step(1);
        check("t2_cool_k", {cooler_en, heater_en, state}, 4'b1010);
        step(19);
        check("t2_cool_k19", {cooler_en, heater_en, state}, 4'b1010);
        cooling_req = 1'b0;
        step(1);
        check("t2_rest_k20", {cooler_en, heater_en, state}, 4'b0011);
        step(6);
        check("t2_idle_k26", {2'b0, state}, 4'h0);
        step(2);

        // 3: heat then immediate changeover request to cool.
        heating_req = 1'b1;
        step(10);
        check("t3_heat_k9", {heater_en, cooler_en, state}, 4'b1001);
        heating_req = 1'b0;
        cooling_req = 1'b1;
        step(1);
        check("t3_rest_k10", {heater_en, cooler_en, state}, 4'b0011);
        step(6);
        check("t3_idle_k16", {heater_en, cooler_en, state}, 4'b0000);
        step(1);
        check("t3_cool_k17", {heater_en, cooler_en, state}, 4'b0110);
        cooling_req = 1'b0;
        step(1);
        check("t3_minon_k18", {2'b0, cooler_en, 1'b0}, 4'b0010);
        step(14);
        check("t3_idle_end", {2'b0, state}, 4'h0);

        // 4: contradictory requests in IDLE.
        check("t4_fault_pre", {3'b0, fault}, 4'h0);
        heating_req = 1'b1;
        cooling_req = 1'b1;
        step(1);
        check("t4_fault_k", {fault, heater_en, cooler_en, fan_en}, 4'b1000);
        check("t4_state_k", {2'b0, state}, 4'h0);
        step(2);
        check("t4_fault_k2", {fault, heater_en, cooler_en, fan_en}, 4'b1000);
        heating_req = 1'b0;
        cooling_req = 1'b0;
        step(1);
        check("t4_fault_k3", {3'b0, fault}, 4'h0);
        step(1);

        // 5: async reset in the middle of HEAT.
        heating_req = 1'b1;
        step(3);
        check("t5_heat", {heater_en, fan_en, state}, 4'b1101);
        #3 rst_n = 1'b0;
        #1;
        check("t5_async", {heater_en, fan_en, state}, 4'b0000);
        step(2);
        check("t5_held", {heater_en, fan_en, state}, 4'b0000);
        #3 rst_n = 1'b1;
        step(1);
        check("t5_reheat", {heater_en, fan_en, state}, 4'b1101);
        heating_req = 1'b0;
        step(15);
        check("t5_idle_end", {2'b0, state}, 4'h0);

        // 6: request raised during REST is ignored until IDLE.
        heating_req = 1'b1;
        step(1);
        heating_req = 1'b0;
        step(9);
        check("t6_rest", {2'b0, state}, 4'h3);
        heating_req = 1'b1;
        step(4);
        check("t6_rest_k13", {heater_en, 1'b0, state}, 4'b0011);
        step(1);
        check("t6_idle_k14", {heater_en, 1'b0, state}, 4'b0000);
        step(1);
        check("t6_heat_k15", {heater_en, 1'b0, state}, 4'b1001);
        heating_req = 1'b0;
        step(16);
        check("t6_idle_end", {2'b0, state}, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
